// File: rtl/scan_pkg.sv
// Shared types and default timing constants for the lidar scan sweep logic.
package scan_pkg;

    // System clock that all pulse widths and dwell times are expressed in.
    localparam int unsigned ClkFreqHz         = 100_000_000;

    // Default servo pulse widths in clk cycles at ClkFreqHz.
    localparam int unsigned PulseMin1ms       = 100_000;
    localparam int unsigned PulseMax2ms       = 200_000;
    localparam int unsigned PulseStep100us    = 10_000;

    // One 20 ms PWM frame of dwell before sampling, and the default ack wait.
    localparam int unsigned SettleFrame20ms   = 2_000_000;
    localparam int unsigned AckTimeoutDefault = 1_000_000;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StAdvance,
        StDone
    } scan_state_e;

    // Bits needed to hold n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_sweep_scheduler_if.sv
// Control/handshake bundle between scan registers, lidar and the sweep scheduler.
interface servo_sweep_scheduler_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic             stop_i;
    logic             continuous_i;
    logic             sample_ack_i;
    logic [WIDTH-1:0] angle_requested_o;
    logic             sample_req_o;
    logic [7:0]       step_index_o;
    logic             direction_o;
    logic             busy_o;
    logic             sweep_done_o;
    logic             sample_miss_o;

    // The scheduler itself.
    modport slave (
        input  start_i,
        input  stop_i,
        input  continuous_i,
        input  sample_ack_i,
        output angle_requested_o,
        output sample_req_o,
        output step_index_o,
        output direction_o,
        output busy_o,
        output sweep_done_o,
        output sample_miss_o
    );

    // Whatever drives the scheduler: control registers plus the lidar ack.
    modport master (
        output start_i,
        output stop_i,
        output continuous_i,
        output sample_ack_i,
        input  angle_requested_o,
        input  sample_req_o,
        input  step_index_o,
        input  direction_o,
        input  busy_o,
        input  sweep_done_o,
        input  sample_miss_o
    );

endinterface

// File: rtl/scan_down_counter.sv
// Loadable down-counter that stops at zero and flags it.
module scan_down_counter #(
    parameter int unsigned CntWidth = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [CntWidth-1:0] load_val_i,
    input  logic                en_i,
    output logic                zero_o
);

    logic [CntWidth-1:0] count_q, count_d;

    // Load has priority over counting; saturate at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/servo_sweep_scheduler.sv
// Steps the servo pulse width across MIN..MAX, dwells, and requests a lidar sample per step.
module servo_sweep_scheduler
    import scan_pkg::*;
#(
    parameter int unsigned      WIDTH         = 32,
    parameter logic [WIDTH-1:0] MIN_PULSE     = WIDTH'(PulseMin1ms),
    parameter logic [WIDTH-1:0] MAX_PULSE     = WIDTH'(PulseMax2ms),
    parameter logic [WIDTH-1:0] STEP_PULSE    = WIDTH'(PulseStep100us),
    parameter int unsigned      SETTLE_CYCLES = SettleFrame20ms,
    parameter int unsigned      ACK_TIMEOUT   = AckTimeoutDefault
) (
    input logic                      clk,
    input logic                      reset,
    servo_sweep_scheduler_if.slave   bus
);

    if (!(MIN_PULSE < MAX_PULSE) || (STEP_PULSE == '0) || (SETTLE_CYCLES < 1)
        || (ACK_TIMEOUT < 1)) begin : g_bad_params
        $error("servo_sweep_scheduler: illegal MIN/MAX/STEP/SETTLE/TIMEOUT parameters");
    end

    localparam int unsigned    SettleW     = cnt_width(SETTLE_CYCLES);
    localparam int unsigned    TimeoutW    = cnt_width(ACK_TIMEOUT);
    localparam logic [SettleW-1:0]  SettleLoad  = SettleW'(SETTLE_CYCLES - 1);
    localparam logic [TimeoutW-1:0] TimeoutLoad = TimeoutW'(ACK_TIMEOUT - 1);

    scan_state_e      state_q, state_d;
    logic [WIDTH-1:0] angle_q, angle_d;
    logic [7:0]       index_q, index_d;
    logic             dir_q, dir_d;
    logic             cont_q, cont_d;
    logic             done_q, done_d;
    logic             miss_q, miss_d;

    logic             settle_load, settle_en, settle_zero;
    logic             timeout_load, timeout_en, timeout_zero;

    // One extra bit so a step can never wrap before it is clamped.
    logic [WIDTH:0]   up_sum, dn_diff;
    logic [WIDTH-1:0] up_next, dn_next;
    logic             at_max, at_min;

    // Clamped neighbour positions in both directions.
    always_comb begin
        up_sum  = {1'b0, angle_q} + {1'b0, STEP_PULSE};
        dn_diff = {1'b0, angle_q} - {1'b0, STEP_PULSE};
        up_next = (up_sum > {1'b0, MAX_PULSE}) ? MAX_PULSE : up_sum[WIDTH-1:0];
        // Top bit set means the subtraction went negative.
        dn_next = (dn_diff[WIDTH] || (dn_diff < {1'b0, MIN_PULSE})) ? MIN_PULSE
                                                                    : dn_diff[WIDTH-1:0];
        at_max  = (angle_q >= MAX_PULSE);
        at_min  = (angle_q <= MIN_PULSE);
    end

    // Next-state and datapath updates; stop overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        index_d = index_q;
        dir_d   = dir_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        miss_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.stop_i) begin
                    state_d = StSettle;
                    angle_d = MIN_PULSE;
                    index_d = '0;
                    dir_d   = 1'b1;
                    cont_d  = bus.continuous_i;
                end
            end
            StSettle: begin
                if (settle_zero) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                // An ack on the expiry cycle still counts as an ack.
                if (bus.sample_ack_i) begin
                    state_d = StAdvance;
                end else if (timeout_zero) begin
                    miss_d  = 1'b1;
                    state_d = StAdvance;
                end
            end
            StAdvance: begin
                if (dir_q) begin
                    if (!at_max) begin
                        angle_d = up_next;
                        index_d = index_q + 8'd1;
                        state_d = StSettle;
                    end else if (cont_q) begin
                        done_d  = 1'b1;
                        dir_d   = 1'b0;
                        angle_d = dn_next;
                        index_d = index_q - 8'd1;
                        state_d = StSettle;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    if (!at_min) begin
                        angle_d = dn_next;
                        index_d = index_q - 8'd1;
                        state_d = StSettle;
                    end else if (cont_q) begin
                        done_d  = 1'b1;
                        dir_d   = 1'b1;
                        angle_d = up_next;
                        index_d = index_q + 8'd1;
                        state_d = StSettle;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                done_d  = 1'b1;
                angle_d = MIN_PULSE;
                index_d = '0;
                dir_d   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (bus.stop_i && (state_q != StIdle)) begin
            state_d = StIdle;
            angle_d = MIN_PULSE;
            index_d = '0;
            dir_d   = 1'b1;
            done_d  = 1'b0;
            miss_d  = 1'b0;
        end

        // Counters reload on entry so each dwell/wait starts fresh.
        settle_load  = (state_d == StSettle) && (state_q != StSettle);
        settle_en    = (state_q == StSettle);
        timeout_load = (state_d == StSample) && (state_q != StSample);
        timeout_en   = (state_q == StSample);
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            angle_q <= MIN_PULSE;
            index_q <= '0;
            dir_q   <= 1'b1;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            index_q <= index_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
            miss_q  <= miss_d;
        end
    end

    scan_down_counter #(
        .CntWidth (SettleW)
    ) u_settle_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (settle_load),
        .load_val_i (SettleLoad),
        .en_i       (settle_en),
        .zero_o     (settle_zero)
    );

    scan_down_counter #(
        .CntWidth (TimeoutW)
    ) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timeout_load),
        .load_val_i (TimeoutLoad),
        .en_i       (timeout_en),
        .zero_o     (timeout_zero)
    );

    assign bus.angle_requested_o = angle_q;
    assign bus.sample_req_o      = (state_q == StSample);
    assign bus.step_index_o      = index_q;
    assign bus.direction_o       = dir_q;
    assign bus.busy_o            = (state_q != StIdle);
    assign bus.sweep_done_o      = done_q;
    assign bus.sample_miss_o     = miss_q;

endmodule

// File: tb/tb_servo_sweep_scheduler.sv
// Self-checking bench: expected sample requests are queued per test and checked on each req.
module tb_servo_sweep_scheduler;

    localparam int unsigned      W      = 32;
    localparam logic [W-1:0]     MinP   = 100;
    localparam logic [W-1:0]     MaxA   = 130;
    localparam logic [W-1:0]     MaxB   = 125;
    localparam logic [W-1:0]     StepP  = 10;
    localparam int unsigned      Settle = 10;
    localparam int unsigned      Tmo    = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic a_start = 1'b0, a_stop = 1'b0, a_cont = 1'b0;
    logic auto_ack = 1'b0, man_ack = 1'b0, b_start = 1'b0;

    servo_sweep_scheduler_if #(.WIDTH(W)) a_if ();
    servo_sweep_scheduler_if #(.WIDTH(W)) b_if ();

    assign a_if.start_i      = a_start;
    assign a_if.stop_i       = a_stop;
    assign a_if.continuous_i = a_cont;
    assign a_if.sample_ack_i = auto_ack | man_ack;
    assign b_if.start_i      = b_start;
    assign b_if.stop_i       = 1'b0;
    assign b_if.continuous_i = 1'b0;
    assign b_if.sample_ack_i = b_if.sample_req_o;

    servo_sweep_scheduler #(
        .WIDTH(W), .MIN_PULSE(MinP), .MAX_PULSE(MaxA), .STEP_PULSE(StepP),
        .SETTLE_CYCLES(Settle), .ACK_TIMEOUT(Tmo)
    ) u_dut_a (.clk(clk), .reset(reset), .bus(a_if.slave));

    servo_sweep_scheduler #(
        .WIDTH(W), .MIN_PULSE(MinP), .MAX_PULSE(MaxB), .STEP_PULSE(StepP),
        .SETTLE_CYCLES(Settle), .ACK_TIMEOUT(Tmo)
    ) u_dut_b (.clk(clk), .reset(reset), .bus(b_if.slave));

    typedef struct {
        logic [W-1:0] angle;
        logic [7:0]   index;
        logic         dir;
        int           gap;      // busy-but-not-requesting cycles before this req
        int           ack_dly;  // cycles after req rise to ack; -1 = never
        int           req_len;  // cycles req stays high
    } req_exp_t;

    req_exp_t     sb[$];
    req_exp_t     tbl_single[4];
    req_exp_t     tbl_cont[9];
    req_exp_t     tbl_miss[4];
    req_exp_t     tbl_stop[3];
    logic [W-1:0] b_exp[4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic req_exp_t mk(input int angle, input int idx, input bit dir,
                                    input int gap, input int dly, input int len);
        req_exp_t r;
        r.angle   = W'(angle);
        r.index   = 8'(idx);
        r.dir     = dir;
        r.gap     = gap;
        r.ack_dly = dly;
        r.req_len = len;
        return r;
    endfunction

    // Monitor / lidar model, sampled 1 time unit after each rising edge.
    int           seen_cnt = 0, done_cnt = 0, miss_cnt = 0, b_done_cnt = 0;
    int           gap = 0, len = 0, ack_cnt = -1, exp_len = 0;
    logic         req_prev = 1'b0, b_req_prev = 1'b0;
    logic [W-1:0] last_angle = '0;
    logic [W-1:0] done_log[$], miss_log[$], b_log[$];
    req_exp_t     e;

    always @(posedge clk) begin
        #1;
        auto_ack = 1'b0;
        if (a_if.sample_req_o && !req_prev) begin
            seen_cnt++;
            last_angle = a_if.angle_requested_o;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_req: got req at angle %0d, required none",
                         a_if.angle_requested_o);
                ack_cnt = 0;
                exp_len = 1;
            end else begin
                e = sb.pop_front();
                check("req_angle", a_if.angle_requested_o, e.angle);
                check("req_index", a_if.step_index_o, e.index);
                check("req_dir", a_if.direction_o, e.dir);
                check("req_dwell", gap, e.gap);
                ack_cnt = e.ack_dly;
                exp_len = e.req_len;
            end
            len = 0;
            gap = 0;
        end
        if (a_if.sample_req_o) len++;
        if (!a_if.sample_req_o && req_prev) check("req_len", len, exp_len);
        if (!a_if.busy_o) gap = 0;
        else if (!a_if.sample_req_o) gap++;
        if (ack_cnt == 0) begin
            auto_ack = 1'b1;
            ack_cnt  = -1;
        end else if (ack_cnt > 0) begin
            ack_cnt--;
        end
        if (a_if.sweep_done_o) begin
            done_cnt++;
            done_log.push_back(last_angle);
        end
        if (a_if.sample_miss_o) begin
            miss_cnt++;
            miss_log.push_back(last_angle);
        end
        if (b_if.sample_req_o && !b_req_prev) b_log.push_back(b_if.angle_requested_o);
        if (b_if.sweep_done_o) b_done_cnt++;
        req_prev   = a_if.sample_req_o;
        b_req_prev = b_if.sample_req_o;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_seen(input int n, input int budget);
        int k = 0;
        while (seen_cnt < n && k < budget) begin
            tick();
            k++;
        end
        if (seen_cnt < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_seen: saw %0d reqs, required %0d", seen_cnt, n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (a_if.busy_o && k < budget) begin
            tick();
            k++;
        end
        check("wait_idle_busy", a_if.busy_o, 0);
    endtask

    task automatic pulse_start(input logic cont);
        a_cont  = cont;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic check_parked(input string tag);
        check({tag, "_busy"}, a_if.busy_o, 0);
        check({tag, "_req"}, a_if.sample_req_o, 0);
        check({tag, "_angle"}, a_if.angle_requested_o, MinP);
        check({tag, "_index"}, a_if.step_index_o, 0);
        check({tag, "_dir"}, a_if.direction_o, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, m0, k;

        tbl_single[0] = mk(100, 0, 1, 10, 2, 3);
        tbl_single[1] = mk(110, 1, 1, 11, 2, 3);
        tbl_single[2] = mk(120, 2, 1, 11, 2, 3);
        tbl_single[3] = mk(130, 3, 1, 11, 2, 3);

        tbl_cont[0] = mk(100, 0, 1, 10, 2, 3);
        tbl_cont[1] = mk(110, 1, 1, 11, 2, 3);
        tbl_cont[2] = mk(120, 2, 1, 11, 2, 3);
        tbl_cont[3] = mk(130, 3, 1, 11, 2, 3);
        tbl_cont[4] = mk(120, 2, 0, 11, 2, 3);
        tbl_cont[5] = mk(110, 1, 0, 11, 2, 3);
        tbl_cont[6] = mk(100, 0, 0, 11, 2, 3);
        tbl_cont[7] = mk(110, 1, 1, 11, 2, 3);
        tbl_cont[8] = mk(120, 2, 1, 11, 2, 3);

        tbl_miss[0] = mk(100, 0, 1, 10, 2, 3);
        tbl_miss[1] = mk(110, 1, 1, 11, -1, 8);
        tbl_miss[2] = mk(120, 2, 1, 11, 2, 3);
        tbl_miss[3] = mk(130, 3, 1, 11, 2, 3);

        tbl_stop[0] = mk(100, 0, 1, 10, 2, 3);
        tbl_stop[1] = mk(110, 1, 1, 11, 2, 3);
        tbl_stop[2] = mk(120, 2, 1, 11, -1, 1);

        b_exp[0] = 100;
        b_exp[1] = 110;
        b_exp[2] = 120;
        b_exp[3] = 125;

        // Reset and idle.
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        check_parked("reset");
        check("reset_done", a_if.sweep_done_o, 0);
        check("reset_miss", a_if.sample_miss_o, 0);
        check("reset_b_angle", b_if.angle_requested_o, MinP);

        // Single pass, ack two cycles after each req.
        s0 = seen_cnt; d0 = done_cnt; m0 = miss_cnt;
        done_log.delete();
        for (int i = 0; i < 4; i++) sb.push_back(tbl_single[i]);
        pulse_start(1'b0);
        wait_idle(300);
        check("single_reqs", seen_cnt - s0, 4);
        check("single_done", done_cnt - d0, 1);
        check("single_done_at", done_log.size() > 0 ? done_log[0] : '0, 130);
        check("single_nomiss", miss_cnt - m0, 0);
        check("single_sb_empty", sb.size(), 0);
        check_parked("single_end");

        // Non-multiple span on the MAX=125 instance.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        k = 0;
        while (b_if.busy_o && k < 300) begin
            tick();
            k++;
        end
        check("clamp_busy", b_if.busy_o, 0);
        check("clamp_reqs", b_log.size(), 4);
        for (int i = 0; i < 4; i++) check("clamp_angle", i < b_log.size() ? b_log[i] : '0, b_exp[i]);
        check("clamp_done", b_done_cnt, 1);
        check("clamp_park", b_if.angle_requested_o, MinP);

        // Continuous ping-pong, nine samples, then stop.
        s0 = seen_cnt; d0 = done_cnt;
        done_log.delete();
        for (int i = 0; i < 9; i++) sb.push_back(tbl_cont[i]);
        pulse_start(1'b1);
        wait_seen(s0 + 9, 400);
        repeat (4) tick();
        a_stop = 1'b1;
        tick();
        a_stop = 1'b0;
        a_cont = 1'b0;
        check_parked("cont_stop");
        check("cont_done", done_cnt - d0, 2);
        check("cont_done_at_max", done_log.size() > 0 ? done_log[0] : '0, 130);
        check("cont_done_at_min", done_log.size() > 1 ? done_log[1] : '0, 100);
        check("cont_sb_empty", sb.size(), 0);

        // Missing ack at the second position.
        s0 = seen_cnt; m0 = miss_cnt;
        miss_log.delete();
        for (int i = 0; i < 4; i++) sb.push_back(tbl_miss[i]);
        pulse_start(1'b0);
        wait_idle(400);
        check("miss_count", miss_cnt - m0, 1);
        check("miss_at", miss_log.size() > 0 ? miss_log[0] : '0, 110);
        check("miss_reqs", seen_cnt - s0, 4);
        check("miss_sb_empty", sb.size(), 0);

        // Stop and start together while sampling at 120.
        s0 = seen_cnt; d0 = done_cnt;
        for (int i = 0; i < 3; i++) sb.push_back(tbl_stop[i]);
        pulse_start(1'b0);
        wait_seen(s0 + 3, 200);
        a_stop  = 1'b1;
        a_start = 1'b1;
        tick();
        a_stop  = 1'b0;
        a_start = 1'b0;
        check_parked("stop");
        tick();
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        tick();
        check("stop_late_ack_busy", a_if.busy_o, 0);
        check("stop_no_done", done_cnt - d0, 0);
        check("stop_sb_empty", sb.size(), 0);
        for (int i = 0; i < 4; i++) sb.push_back(tbl_single[i]);
        pulse_start(1'b0);
        wait_idle(300);
        check("restart_done", done_cnt - d0, 1);
        check("restart_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of a dwell.
        pulse_start(1'b0);
        repeat (3) tick();
        check("pre_reset_busy", a_if.busy_o, 1);
        #1 reset = 1'b1;
        #1;
        check("async_reset_busy", a_if.busy_o, 0);
        check("async_reset_angle", a_if.angle_requested_o, MinP);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check_parked("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
